// File: rtl/apb_register_bank.sv
// APB completer with ID, control, transfer/error counters and scratch registers.
// Programmable wait states; all completer outputs are registered.
module apb_register_bank #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] ID_VALUE   = 32'h4150_4252
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int IW  = ADDR_WIDTH - LSB;
    localparam logic [DATA_WIDTH-1:0] ID_W  = DATA_WIDTH'(ID_VALUE);
    localparam logic [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            wait_q, wait_d;
    logic [DATA_WIDTH-1:0] xfer_q, xfer_d;
    logic [DATA_WIDTH-1:0] err_q, err_d;
    logic [DATA_WIDTH-1:0] scratch_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] scratch_d [NUM_REGS];
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;

    logic                  unused_lsb;
    logic [IW-1:0]         a_idx;
    logic                  a_wr;
    logic [31:0]           a_num;
    logic [31:0]           c_num;
    logic                  a_err;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  enter_done;

    assign unused_lsb = ^paddr[LSB-1:0];

    // The decode used when entering DONE: live bus in IDLE, latched copy in WAIT
    assign a_idx = (state_q == S_IDLE) ? paddr[ADDR_WIDTH-1:LSB] : idx_q;
    assign a_wr  = (state_q == S_IDLE) ? pwrite : wr_q;
    assign a_num = 32'(a_idx);
    assign c_num = 32'(idx_q);

    assign a_err = (a_num >= 32'(4 + NUM_REGS)) ||
                   (a_wr && (a_num == 32'd0 || a_num == 32'd2 ||
                             a_num == 32'd3));

    always_comb begin
        a_rdata = '0;
        if (a_num == 32'd0) begin
            a_rdata = ID_W;
        end else if (a_num == 32'd1) begin
            a_rdata = DATA_WIDTH'(wait_q);
        end else if (a_num == 32'd2) begin
            a_rdata = xfer_q;
        end else if (a_num == 32'd3) begin
            a_rdata = err_q;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a_num == 32'(4 + i)) begin
                a_rdata = scratch_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        xfer_d     = xfer_q;
        err_d      = err_q;
        scratch_d  = scratch_q;
        pready_d   = 1'b0;
        prdata_d   = '0;
        pslverr_d  = 1'b0;
        enter_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    idx_d   = paddr[ADDR_WIDTH-1:LSB];
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    if (wait_q == 4'd0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        cnt_d   = wait_q;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                xfer_d  = xfer_q + ONE_W;
                if (pslverr_q) begin
                    err_d = err_q + ONE_W;
                end
                // pslverr_q still describes this transfer, so it gates the commit
                if (wr_q && !pslverr_q) begin
                    if (c_num == 32'd1) begin
                        wait_d = wdata_q[3:0];
                        if (wdata_q[8]) begin
                            xfer_d = '0;
                            err_d  = '0;
                        end
                    end
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (c_num == 32'(4 + i)) begin
                            scratch_d[i] = wdata_q;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_done) begin
            pready_d  = 1'b1;
            pslverr_d = a_err;
            prdata_d  = (a_wr || a_err) ? '0 : a_rdata;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            xfer_q    <= '0;
            err_q     <= '0;
            scratch_q <= '{default: '0};
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            xfer_q    <= xfer_d;
            err_q     <= err_d;
            scratch_q <= scratch_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

endmodule
